floor_request_queue: RTL
========================

// Module: floor_request_queue
// PURPOSE
//   Downstream of the per-button one-pulse synchronisers. Latches single-cycle call pulses into
//   per-floor pending bits and clears them when the car serves a floor. Runs a SCAN-style direction
//   state machine that hands the elevator controller one target floor. An evacuation override
//   forces the target to floor 0 and discards all calls.
// PARAMETERS
//   FLOORS   4                 number of floors served (>=2)
//   FW       $clog2(FLOORS)    floor index width (derived, not overridden)
// PORTS
//   clk           in   1       system clock
//   reset         in   1       synchronous, active-high reset
//   req_pulse     in   FLOORS  one-cycle call pulses, bit i = floor i (from button syncs)
//   cur_floor     in   FW      floor the car is currently at or passing
//   at_floor      in   1       car stopped with doors open at cur_floor (service event)
//   evac          in   1       evacuation level request
//   pending       out  FLOORS  latched outstanding calls
//   target        out  FW      floor the controller drives toward
//   target_valid  out  1       target is meaningful
//   dir           out  2       2'b00 IDLE, 2'b01 UP, 2'b10 DOWN
//   evac_active   out  1       queue is in EVAC state
// BEHAVIOUR
//   Reset: pending=0, state=IDLE, target=0, target_valid=0, dir=IDLE, evac_active=0.
//     Reset mid-operation drops all calls immediately.
//   Pending bits (register, 1-cycle latency):
//     - pending[i] sets on the edge after req_pulse[i]=1.
//     - It clears on the edge after at_floor=1 with cur_floor==i.
//     - If set and clear coincide for the same floor, clear wins: the car is already there.
//     - If cur_floor>=FLOORS, at_floor is ignored.
//     - In EVAC, or in the cycle evac=1, pending is forced to 0 and req_pulse is ignored.
//   Scan (combinational, from the registered pending and cur_floor):
//     - above = nearest set index > cur_floor; below = nearest set index < cur_floor.
//     - here = pending[cur_floor].
//   State machine (registered; outputs registered with the state):
//     - The target updates 1 edge after pending, so it appears 2 edges after the pulse.
//     IDLE: priority order is
//       here   -> stay IDLE, target=cur_floor, valid=1;
//       above  -> UP;
//       below  -> DOWN;
//       none   -> valid=0, target held.
//     UP:
//       above  -> stay UP, target=above, valid=1;
//       else below -> DOWN;
//       else here  -> IDLE, target=cur_floor;
//       else IDLE, valid=0.
//     DOWN: mirror of UP, with below/above swapped.
//     Direction hysteresis: the machine never reverses while any call remains in the current
//       direction, even if a nearer call exists behind the car.
//     EVAC:
//       - evac=1 in any state -> EVAC on the next edge; this overrides everything.
//       - In EVAC: target=0, valid=1, evac_active=1.
//       - dir=DOWN while cur_floor>0, IDLE at 0.
//       - evac=0 in EVAC -> IDLE with pending=0.
//     dir output: IDLE/UP/DOWN as the state, or per the EVAC rule above.
//   Widths: all comparisons are unsigned FW-bit. There is no wrap-around: floor 0 has no below,
//     floor FLOORS-1 has no above.
// STRUCTURE
//   elevator_pkg:
//     - dir_t enum {DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10};
//     - queue_state_t enum {Q_IDLE, Q_UP, Q_DOWN, Q_EVAC};
//     - default FLOORS constant.
//   Sub-module floor_scan:
//     - combinational;
//     - inputs: pending, cur_floor;
//     - outputs: above_vld/above_idx, below_vld/below_idx, here.
//   The top level holds the pending register, state register and output registers.
// TESTING (FLOORS=4)
//   1. Reset, idle inputs: all outputs 0 and dir=00; held for 10 cycles.
//   2. cur_floor=0, req_pulse=4'b1000 for 1 cycle:
//      - pending=4'b1000 one edge later;
//      - dir=01, target=3, valid=1 one edge after that.
//   3. cur_floor=1, dir=UP, pending=4'b1001 (floors 0 and 3):
//      - target stays 3 in UP;
//      - after at_floor with cur_floor=3: pending=4'b0001, then dir=10, target=0.
//   4. at_floor=1, cur_floor=2 and req_pulse=4'b0100 in the same cycle:
//      - pending[2] stays 0;
//      - state IDLE, valid=0.
//   5. pending=4'b1010, cur_floor=2, evac=1 for 1 cycle:
//      - next edge: pending=0, evac_active=1, target=0, dir=10;
//      - req_pulse=4'b1111 during EVAC is ignored;
//      - after evac=0: IDLE with pending=0.
//   6. Assert reset while in UP with pending=4'b1100:
//      - next edge: all outputs return to their reset values.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the elevator call-queue logic: direction codes and queue states.
package elevator_pkg;

    localparam int FLOORS_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_UP,
        Q_DOWN,
        Q_EVAC
    } queue_state_t;

endpackage

// File: rtl/floor_scan.sv
// Combinational scan of the pending calls relative to the car position:
// nearest call above, nearest call below, and whether the current floor is called.
module floor_scan #(
    parameter int FLOORS = 4,
    parameter int FW     = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0] i_pending,
    input  logic [FW-1:0]     i_cur_floor,
    output logic              o_above_vld,
    output logic [FW-1:0]     o_above_idx,
    output logic              o_below_vld,
    output logic [FW-1:0]     o_below_idx,
    output logic              o_here
);

    always_comb begin
        o_above_vld = 1'b0;
        o_above_idx = '0;
        o_below_vld = 1'b0;
        o_below_idx = '0;
        o_here      = 1'b0;
        // Walk downward so the last hit is the nearest floor above the car.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (FW'(i) > i_cur_floor)) begin
                o_above_vld = 1'b1;
                o_above_idx = FW'(i);
            end
        end
        // Walk upward so the last hit is the nearest floor below the car.
        for (int i = 0; i < FLOORS; i++) begin
            if (i_pending[i] && (FW'(i) < i_cur_floor)) begin
                o_below_vld = 1'b1;
                o_below_idx = FW'(i);
            end
            if (i_pending[i] && (FW'(i) == i_cur_floor)) begin
                o_here = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_queue.sv
// Latches call pulses into per-floor pending bits and runs a SCAN direction machine
// that hands the elevator controller one target floor, with an evacuation override.
module floor_request_queue
    import elevator_pkg::*;
#(
    parameter  int FLOORS = FLOORS_DEFAULT,
    localparam int FW     = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] i_req_pulse,
    input  logic [FW-1:0]     i_cur_floor,
    input  logic              i_at_floor,
    input  logic              i_evac,
    output logic [FLOORS-1:0] o_pending,
    output logic [FW-1:0]     o_target,
    output logic              o_target_valid,
    output logic [1:0]        o_dir,
    output logic              o_evac_active,
    output logic [1:0]        o_dbg_state
);

    queue_state_t      r_state;
    logic [FLOORS-1:0] r_pending;
    logic [FW-1:0]     r_target;
    logic              r_valid;
    dir_t              r_dir;

    queue_state_t      w_state_next;
    logic [FLOORS-1:0] w_pending_next;
    logic [FLOORS-1:0] w_clr_mask;
    logic [FW-1:0]     w_target_next;
    logic              w_valid_next;
    dir_t              w_dir_next;

    logic              w_above_vld;
    logic [FW-1:0]     w_above_idx;
    logic              w_below_vld;
    logic [FW-1:0]     w_below_idx;
    logic              w_here;

    floor_scan #(
        .FLOORS (FLOORS),
        .FW     (FW)
    ) u_scan (
        .i_pending   (r_pending),
        .i_cur_floor (i_cur_floor),
        .o_above_vld (w_above_vld),
        .o_above_idx (w_above_idx),
        .o_below_vld (w_below_vld),
        .o_below_idx (w_below_idx),
        .o_here      (w_here)
    );

    // A floor index outside the served range never matches, so such service events are ignored.
    always_comb begin
        w_clr_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i_at_floor && (FW'(i) == i_cur_floor)) begin
                w_clr_mask[i] = 1'b1;
            end
        end
    end

    // Clear is applied after set so a call at the floor being served is dropped.
    always_comb begin
        w_pending_next = (r_pending | i_req_pulse) & ~w_clr_mask;
        if (i_evac || (r_state == Q_EVAC)) begin
            w_pending_next = '0;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_valid_next  = r_valid;
        w_dir_next    = r_dir;
        if (i_evac) begin
            w_state_next  = Q_EVAC;
            w_target_next = '0;
            w_valid_next  = 1'b1;
            w_dir_next    = (i_cur_floor != '0) ? DIR_DOWN : DIR_IDLE;
        end else begin
            case (r_state)
                Q_IDLE: begin
                    if (w_here) begin
                        w_state_next  = Q_IDLE;
                        w_target_next = i_cur_floor;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_IDLE;
                    end else if (w_above_vld) begin
                        w_state_next  = Q_UP;
                        w_target_next = w_above_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_UP;
                    end else if (w_below_vld) begin
                        w_state_next  = Q_DOWN;
                        w_target_next = w_below_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_DOWN;
                    end else begin
                        w_valid_next  = 1'b0;
                        w_dir_next    = DIR_IDLE;
                    end
                end
                // Keep sweeping while calls remain ahead; reverse only when none are left.
                Q_UP: begin
                    if (w_above_vld) begin
                        w_target_next = w_above_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_UP;
                    end else if (w_below_vld) begin
                        w_state_next  = Q_DOWN;
                        w_target_next = w_below_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_DOWN;
                    end else begin
                        w_state_next  = Q_IDLE;
                        w_dir_next    = DIR_IDLE;
                        w_valid_next  = w_here;
                        if (w_here) w_target_next = i_cur_floor;
                    end
                end
                Q_DOWN: begin
                    if (w_below_vld) begin
                        w_target_next = w_below_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_DOWN;
                    end else if (w_above_vld) begin
                        w_state_next  = Q_UP;
                        w_target_next = w_above_idx;
                        w_valid_next  = 1'b1;
                        w_dir_next    = DIR_UP;
                    end else begin
                        w_state_next  = Q_IDLE;
                        w_dir_next    = DIR_IDLE;
                        w_valid_next  = w_here;
                        if (w_here) w_target_next = i_cur_floor;
                    end
                end
                default: begin
                    w_state_next  = Q_IDLE;
                    w_valid_next  = 1'b0;
                    w_dir_next    = DIR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= Q_IDLE;
            r_pending <= '0;
            r_target  <= '0;
            r_valid   <= 1'b0;
            r_dir     <= DIR_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_target  <= w_target_next;
            r_valid   <= w_valid_next;
            r_dir     <= w_dir_next;
        end
    end

    assign o_pending      = r_pending;
    assign o_target       = r_target;
    assign o_target_valid = r_valid;
    assign o_dir          = r_dir;
    assign o_evac_active  = (r_state == Q_EVAC);
    assign o_dbg_state    = r_state;

endmodule
